mmio_bus_fabric: RTL and testbench

//  Parametrised memory-mapped interconnect between the CPU data port and up to 2**SEL_W slaves.

---
 rtl/mmio_bus_fabric.sv | 125 ++++++++++++
 tb/tb_mmio_bus_fabric.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric: CPU data-port interconnect to up to 2**SEL_W memory-mapped slaves.
// Writes are single-cycle strobes to the decoded slot. Reads take a per-slot latency
// and complete with a waitrequest/rddata_valid handshake. Unmapped accesses set a sticky error.
module mmio_bus_fabric #(
  parameter int unsigned                     ADDR_W     = 16,
  parameter int unsigned                     DATA_W     = 16,
  parameter int unsigned                     SEL_W      = 4,
  parameter int unsigned                     WORD_SHIFT = 1,
  parameter logic [(2**SEL_W)-1:0]           SLOT_EN    = 16'h000D,
  parameter logic [2*(2**SEL_W)-1:0]         RD_LAT     = 32'h55,
  parameter logic [DATA_W-1:0]               DEF_RDDATA = '0
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic [ADDR_W-1:0]                  i_cpu_addr,
  input  logic                               i_cpu_rd,
  input  logic                               i_cpu_wr,
  input  logic [DATA_W-1:0]                  i_cpu_wrdata,
  output logic                               o_cpu_waitrequest,
  output logic [DATA_W-1:0]                  o_cpu_rddata,
  output logic                               o_cpu_rddata_valid,
  output logic [ADDR_W-1:0]                  o_slv_addr,
  output logic [DATA_W-1:0]                  o_slv_wrdata,
  output logic [(2**SEL_W)-1:0]              o_slv_wr,
  output logic [(2**SEL_W)-1:0]              o_slv_rd,
  input  logic [(2**SEL_W)*DATA_W-1:0]       i_slv_rddata,
  output logic                               o_err_unmapped,
  input  logic                               i_err_clr
);

  localparam int unsigned NSLOT = 2**SEL_W;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t             state, state_nxt;
  logic [1:0]         cnt, cnt_nxt;
  logic [SEL_W-1:0]   lsel, lsel_nxt;
  logic               err_set;

  logic [SEL_W-1:0]   sel;
  logic               sel_mapped;
  logic [1:0]         sel_lat;

  // Slot decode from the top address bits
  always_comb begin
    sel        = i_cpu_addr[ADDR_W-1 -: SEL_W];
    sel_mapped = SLOT_EN[sel];
    sel_lat    = RD_LAT[2*sel +: 2];
  end

  // State, countdown, latched slot and sticky error registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      lsel           <= '0;
      o_err_unmapped <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      lsel           <= lsel_nxt;
      o_err_unmapped <= (o_err_unmapped & ~i_err_clr) | err_set;
    end
  end

  // Next-state and handshake/strobe outputs; everything forced low while in reset
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    lsel_nxt           = lsel;
    err_set            = 1'b0;
    o_cpu_waitrequest  = 1'b0;
    o_cpu_rddata       = '0;
    o_cpu_rddata_valid = 1'b0;
    o_slv_wr           = '0;
    o_slv_rd           = '0;
    o_slv_addr         = '0;
    o_slv_wrdata       = '0;
    if (!i_reset) begin
      o_slv_addr   = i_cpu_addr >> WORD_SHIFT;
      o_slv_wrdata = i_cpu_wrdata;
      case (state)
        IDLE: begin
          if (i_cpu_wr) begin
            // Write wins over a simultaneous read
            o_slv_wr[sel] = sel_mapped;
            err_set       = ~sel_mapped;
          end else if (i_cpu_rd) begin
            if (!sel_mapped) begin
              o_cpu_rddata_valid = 1'b1;
              o_cpu_rddata       = DEF_RDDATA;
              err_set            = 1'b1;
            end else if (sel_lat == 2'd0) begin
              o_slv_rd[sel]      = 1'b1;
              o_cpu_rddata_valid = 1'b1;
              o_cpu_rddata       = i_slv_rddata[DATA_W*sel +: DATA_W];
            end else begin
              o_slv_rd[sel]      = 1'b1;
              o_cpu_waitrequest  = 1'b1;
              lsel_nxt           = sel;
              cnt_nxt            = sel_lat - 2'd1;
              state_nxt          = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt != 2'd0) begin
            o_cpu_waitrequest = 1'b1;
            cnt_nxt           = cnt - 2'd1;
          end else begin
            o_cpu_rddata_valid = 1'b1;
            o_cpu_rddata       = i_slv_rddata[DATA_W*lsel +: DATA_W];
            state_nxt          = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  if (NSLOT < 1) begin : g_bad_param
    $error("SEL_W must give at least one slot");
  end

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Self-checking bench for mmio_bus_fabric: directed cases plus randomized reads/writes
// checked against a transaction-level model of slot decode, latency and the sticky error.
module tb_mmio_bus_fabric;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned NSLOT  = 16;
  localparam logic [15:0] SLOT_EN = 16'h000D;
  localparam logic [31:0] RD_LAT  = 32'h0000_0035;  // slot0=1, slot1=1, slot2=3, slot3=0
  localparam logic [15:0] DEF_RD  = 16'hDEAD;

  logic                    i_clk = 1'b0;
  logic                    i_reset;
  logic [ADDR_W-1:0]       i_cpu_addr;
  logic                    i_cpu_rd;
  logic                    i_cpu_wr;
  logic [DATA_W-1:0]       i_cpu_wrdata;
  logic                    o_cpu_waitrequest;
  logic [DATA_W-1:0]       o_cpu_rddata;
  logic                    o_cpu_rddata_valid;
  logic [ADDR_W-1:0]       o_slv_addr;
  logic [DATA_W-1:0]       o_slv_wrdata;
  logic [NSLOT-1:0]        o_slv_wr;
  logic [NSLOT-1:0]        o_slv_rd;
  logic [NSLOT*DATA_W-1:0] i_slv_rddata;
  logic                    o_err_unmapped;
  logic                    i_err_clr;

  logic [DATA_W-1:0] slv_mem [NSLOT];
  int n_tests = 0;
  int n_fail  = 0;
  bit err_exp = 1'b0;

  mmio_bus_fabric #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .WORD_SHIFT(1),
    .SLOT_EN(SLOT_EN), .RD_LAT(RD_LAT), .DEF_RDDATA(DEF_RD)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cpu_addr(i_cpu_addr), .i_cpu_rd(i_cpu_rd), .i_cpu_wr(i_cpu_wr),
    .i_cpu_wrdata(i_cpu_wrdata),
    .o_cpu_waitrequest(o_cpu_waitrequest), .o_cpu_rddata(o_cpu_rddata),
    .o_cpu_rddata_valid(o_cpu_rddata_valid),
    .o_slv_addr(o_slv_addr), .o_slv_wrdata(o_slv_wrdata),
    .o_slv_wr(o_slv_wr), .o_slv_rd(o_slv_rd), .i_slv_rddata(i_slv_rddata),
    .o_err_unmapped(o_err_unmapped), .i_err_clr(i_err_clr)
  );

  always #5 i_clk = ~i_clk;

  always_comb
    for (int i = 0; i < NSLOT; i++) i_slv_rddata[DATA_W*i +: DATA_W] = slv_mem[i];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int slot);
    return int'((RD_LAT >> (2 * slot)) & 32'd3);
  endfunction

  function automatic bit is_mapped(input int slot);
    return SLOT_EN[slot];
  endfunction

  // Advance one clock; model the sticky error (set beats clear) at the edge
  task automatic tick(input bit set);
    if (!i_reset) err_exp = (err_exp & ~i_err_clr) | set;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input bit also_rd);
    int slot;
    logic [15:0] exp_wr;
    slot = int'(addr >> 12);
    exp_wr = is_mapped(slot) ? (16'd1 << slot) : 16'd0;
    i_cpu_addr = addr; i_cpu_wrdata = data; i_cpu_wr = 1'b1; i_cpu_rd = also_rd;
    #1;
    check("wr_strobe", 64'(o_slv_wr), 64'(exp_wr));
    check("wr_data", 64'(o_slv_wrdata), 64'(data));
    check("wr_no_rd", 64'(o_slv_rd), 64'd0);
    check("wr_no_wait", 64'(o_cpu_waitrequest), 64'd0);
    check("wr_no_valid", 64'(o_cpu_rddata_valid), 64'd0);
    tick(!is_mapped(slot));
    i_cpu_wr = 1'b0; i_cpu_rd = 1'b0;
    check("wr_err", 64'(o_err_unmapped), 64'(err_exp));
  endtask

  task automatic do_read(input logic [15:0] addr, input bit force_d, input logic [15:0] d);
    int slot, lat;
    logic [15:0] exp_d;
    slot = int'(addr >> 12);
    for (int i = 0; i < NSLOT; i++) slv_mem[i] = 16'($urandom);
    if (force_d) slv_mem[slot] = d;
    lat   = is_mapped(slot) ? lat_of(slot) : 0;
    exp_d = is_mapped(slot) ? slv_mem[slot] : DEF_RD;
    i_cpu_addr = addr; i_cpu_rd = 1'b1; i_cpu_wr = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      #1;
      check("rd_wait", 64'(o_cpu_waitrequest), 64'(c < lat));
      check("rd_valid", 64'(o_cpu_rddata_valid), 64'(c == lat));
      check("rd_data", 64'(o_cpu_rddata), (c == lat) ? 64'(exp_d) : 64'd0);
      check("rd_strobe", 64'(o_slv_rd),
            (c == 0 && is_mapped(slot)) ? (64'd1 << slot) : 64'd0);
      check("rd_no_wr", 64'(o_slv_wr), 64'd0);
      if (c == 0) check("rd_addr", 64'(o_slv_addr), 64'(addr >> 1));
      tick(c == 0 && !is_mapped(slot));
    end
    i_cpu_rd = 1'b0;
    check("rd_err", 64'(o_err_unmapped), 64'(err_exp));
  endtask

  initial begin
    for (int i = 0; i < NSLOT; i++) slv_mem[i] = '0;
    i_reset = 1'b1; i_cpu_addr = 16'h2468; i_cpu_rd = 1'b1; i_cpu_wr = 1'b0;
    i_cpu_wrdata = 16'h5555; i_err_clr = 1'b0;
    #2;
    check("rst_wait", 64'(o_cpu_waitrequest), 64'd0);
    check("rst_valid", 64'(o_cpu_rddata_valid), 64'd0);
    check("rst_slv_addr", 64'(o_slv_addr), 64'd0);
    check("rst_slv_rd", 64'(o_slv_rd), 64'd0);
    check("rst_err", 64'(o_err_unmapped), 64'd0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_reset = 1'b0; i_cpu_rd = 1'b0;

    do_write(16'h3000, 16'h00AB, 1'b0);
    do_read(16'h0004, 1'b1, 16'h1234);
    do_read(16'h2000, 1'b1, 16'h005A);
    do_read(16'h3002, 1'b0, 16'h0000);
    do_read(16'h5000, 1'b0, 16'h0000);
    check("err_set", 64'(o_err_unmapped), 64'd1);
    i_err_clr = 1'b1; tick(1'b0); i_err_clr = 1'b0;
    check("err_clr", 64'(o_err_unmapped), 64'd0);
    do_write(16'h0000, 16'h0F0F, 1'b1);

    // Reset in the middle of a 3-cycle read drops it
    for (int i = 0; i < NSLOT; i++) slv_mem[i] = 16'($urandom);
    i_cpu_addr = 16'h2010; i_cpu_rd = 1'b1;
    tick(1'b0);
    check("mid_wait", 64'(o_cpu_waitrequest), 64'd1);
    i_reset = 1'b1; #1;
    err_exp = 1'b0;
    check("mid_rst_wait", 64'(o_cpu_waitrequest), 64'd0);
    check("mid_rst_valid", 64'(o_cpu_rddata_valid), 64'd0);
    check("mid_rst_addr", 64'(o_slv_addr), 64'd0);
    tick(1'b0); tick(1'b0);
    i_reset = 1'b0; i_cpu_rd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("post_rst_valid", 64'(o_cpu_rddata_valid), 64'd0);
      check("post_rst_wait", 64'(o_cpu_waitrequest), 64'd0);
      tick(1'b0);
    end
    do_read(16'h0006, 1'b0, 16'h0000);

    // Randomized mix of reads, writes and error clears
    for (int n = 0; n < 60; n++) begin
      logic [15:0] a;
      int op;
      a  = 16'($urandom);
      op = int'($urandom_range(0, 4));
      if (op <= 1) do_write(a, 16'($urandom), op == 1);
      else if (op <= 3) do_read(a, 1'b0, 16'h0000);
      else begin
        i_err_clr = 1'b1; tick(1'b0); i_err_clr = 1'b0;
        check("rand_clr", 64'(o_err_unmapped), 64'(err_exp));
      end
    end

    // Clear and set in the same cycle: set wins
    i_err_clr = 1'b1;
    do_read(16'h9000, 1'b0, 16'h0000);
    i_err_clr = 1'b0;
    check("set_wins", 64'(o_err_unmapped), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
